// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants for the pwm_bank PWM generator.
//   PWM_NUM_CH / PWM_CNT_W / PWM_PRESC_W : default parameter values
//   PWM_PERIOD_ACT_RST                   : reset value of the active period
//                                          (all ones, sliced to CNT_W)
//   pwm_idx_w()                          : width of a channel index bus
package pwm_pkg;

    localparam int unsigned PWM_NUM_CH  = 16;
    localparam int unsigned PWM_CNT_W   = 8;
    localparam int unsigned PWM_PRESC_W = 8;

    localparam logic [31:0] PWM_PERIOD_ACT_RST = '1;

    // A single-channel bank still needs a 1-bit index bus.
    function automatic int unsigned pwm_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_bank_if.sv
// pwm_bank_if: duty write bus from the SPI register file into pwm_bank.
//   duty_wr_en   : single-cycle write strobe
//   duty_wr_ch   : target channel index
//   duty_wr_data : duty value, CNT_W+1 bits so that 100% duty is reachable
// Modports: master (register file side), slave (pwm_bank side).
interface pwm_bank_if
    import pwm_pkg::*;
#(
    parameter int unsigned NUM_CH = PWM_NUM_CH,
    parameter int unsigned CNT_W  = PWM_CNT_W
);

    localparam int unsigned CH_W = pwm_idx_w(NUM_CH);

    logic            duty_wr_en;
    logic [CH_W-1:0] duty_wr_ch;
    logic [CNT_W:0]  duty_wr_data;

    modport master (output duty_wr_en, output duty_wr_ch, output duty_wr_data);
    modport slave  (input  duty_wr_en, input  duty_wr_ch, input  duty_wr_data);

endinterface

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM output with a double-buffered duty register.
//   clk, rst        : clock, synchronous active-high reset
//   cnt, boundary   : shared period counter and period-boundary strobe
//   en_out, en_pwm  : output enable, PWM mode (0 = static high when enabled)
//   wr_en/ch/data   : duty write bus, decoded against CH_IDX
//   out             : registered PWM output
module pwm_channel #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned CH_W   = 4,
    parameter int unsigned CH_IDX = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CNT_W-1:0] cnt,
    input  logic            boundary,
    input  logic            en_out,
    input  logic            en_pwm,
    input  logic            wr_en,
    input  logic [CH_W-1:0] wr_ch,
    input  logic [CNT_W:0]  wr_data,
    output logic            out
);

    logic            hit;
    logic [CNT_W:0]  duty_shd;
    logic [CNT_W:0]  duty_act;

    assign hit = wr_en && (wr_ch == CH_W'(CH_IDX));

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_shd <= '0;
            duty_act <= '0;
            out      <= 1'b0;
        end else begin
            if (hit) begin
                duty_shd <= wr_data;
            end
            // A write landing on the boundary edge bypasses the shadow.
            if (boundary) begin
                duty_act <= hit ? wr_data : duty_shd;
            end
            out <= en_out & (~en_pwm | ({1'b0, cnt} < duty_act));
        end
    end

endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM generator with prescaler and glitch-free
// duty updates at period boundaries.
//   clk, rst       : clock, synchronous active-high reset
//   en_out, en_pwm : per-channel output enable / PWM mode
//   period         : counter top value (period+1 ticks per period)
//   prescale       : one counter tick every prescale+1 clocks
//   duty_wr        : duty write bus (pwm_bank_if.slave)
//   out            : registered PWM outputs
//   period_start   : registered one-cycle pulse at the start of each period
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int unsigned NUM_CH  = PWM_NUM_CH,
    parameter int unsigned CNT_W   = PWM_CNT_W,
    parameter int unsigned PRESC_W = PWM_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CH-1:0]  en_out,
    input  logic [NUM_CH-1:0]  en_pwm,
    input  logic [CNT_W-1:0]   period,
    input  logic [PRESC_W-1:0] prescale,
    pwm_bank_if.slave          duty_wr,
    output logic [NUM_CH-1:0]  out,
    output logic               period_start
);

    localparam int unsigned CH_W = pwm_idx_w(NUM_CH);

    logic [PRESC_W-1:0] presc_cnt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   period_act;
    logic               tick;
    logic               boundary;

    // >= rather than == so that lowering prescale below the running
    // count ticks at once instead of wrapping the prescaler.
    assign tick     = (presc_cnt >= prescale);
    assign boundary = tick && (cnt == period_act);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt    <= '0;
            cnt          <= '0;
            period_act   <= PWM_PERIOD_ACT_RST[CNT_W-1:0];
            period_start <= 1'b0;
        end else begin
            presc_cnt    <= tick ? '0 : presc_cnt + 1'b1;
            period_start <= boundary;
            if (boundary) begin
                cnt        <= '0;
                period_act <= period;
            end else if (tick) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel #(
            .CNT_W  (CNT_W),
            .CH_W   (CH_W),
            .CH_IDX (i)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .cnt      (cnt),
            .boundary (boundary),
            .en_out   (en_out[i]),
            .en_pwm   (en_pwm[i]),
            .wr_en    (duty_wr.duty_wr_en),
            .wr_ch    (duty_wr.duty_wr_ch),
            .wr_data  (duty_wr.duty_wr_data),
            .out      (out[i])
        );
    end

endmodule

// File: doc/pwm_bank.md
# pwm_bank

Parametrised multi-channel PWM generator, the next generation of the fixed 16-output PWM peripheral behind the SPI register file. It adds the following over the fixed peripheral:

- per-channel duty cycles;
- configurable counter width and period;
- a clock prescaler;
- double-buffered duty updates that take effect only at a period boundary (glitch-free).

It sits between the SPI register file and the output pins. Its `out` bus maps directly onto the chip outputs.

## Interface

Parameters:
- `NUM_CH`, 16: number of PWM channels.
- `CNT_W`, 8: period counter width.
- `PRESC_W`, 8: prescaler width.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: synchronous, active-high reset.
- `en_out`  in  NUM_CH: per-channel output enable.
- `en_pwm`  in  NUM_CH: per-channel PWM mode. When 0, an enabled output is static high.
- `period`  in  CNT_W: counter top value. The period is period+1 ticks.
- `prescale`  in  PRESC_W: one counter tick every prescale+1 clocks.
- `duty_wr_en`  in  1: duty write strobe, single cycle.
- `duty_wr_ch`  in  $clog2(NUM_CH): channel index for the write.
- `duty_wr_data`  in  CNT_W+1: duty value. The extra bit allows 100% duty.
- `out`  out  NUM_CH: registered PWM outputs.
- `period_start`  out  1: registered one-cycle pulse at the start of each period.

## Operation

- **Prescaler:** `presc_cnt` increments every clock. `tick` = (`presc_cnt` >= `prescale`). On `tick`, `presc_cnt` <= 0. The >= compare means a prescale decrease never stalls the prescaler.
- **Counter:** `cnt` increments on `tick`.
- **Boundary:** `boundary` = `tick` && (`cnt` == `period_act`). On `boundary`:
  - `cnt` <= 0;
  - `period_act` <= `period`;
  - every `duty_act[i]` <= `duty_shd[i]`.
- **Duty writes:** on `duty_wr_en`, `duty_shd[duty_wr_ch]` <= `duty_wr_data`.
  - Writes to an index >= NUM_CH are ignored.
  - A write in the boundary cycle is forwarded: `duty_act` loads the new data at that same edge.
  - Multiple writes within one period: the last write wins.
- **Output function, per channel:** `out[i]` <= `en_out[i]` & (~`en_pwm[i]` | (`cnt` < `duty_act[i]`)).
  - The compare is unsigned, with `cnt` zero-extended to CNT_W+1 bits.
  - Duty 0: output always low.
  - Duty > `period_act`: output always high.
  - `period_act` = 0: every tick is a boundary and `cnt` stays at 0.
- **Enables:** `en_out` and `en_pwm` are not buffered. They act on the next output register update.
- **`period_start`:** `period_start` <= `boundary`. No pulse is generated for the period that begins at reset.

## Timing

- **Reset values** (applied on the first edge with `rst` high):
  - `presc_cnt` = 0, `cnt` = 0;
  - all `duty_shd` = 0, all `duty_act` = 0;
  - `period_act` = all ones;
  - `out` = 0, `period_start` = 0.
- **Reset mid-operation:** any output high before reset is 0 in the cycle after the reset edge. Pending shadow writes are discarded.
- **Output latency:** `out` lags the `cnt` value it was computed from by 1 clock. It changes only on a `clk` edge.
- **Duty update latency:** a new duty shows on `out` 1 clock after the first boundary following the write.
- **Period length:** (period+1)·(prescale+1) clocks. `period_start` repeats at exactly this interval.
- **`period_start` alignment:** the pulse is high in the same cycle that `out` first reflects `cnt` = 0 … more precisely, in the cycle whose `out` update is computed from `cnt` = 0 of the new period.
- **Prescale changes:** take effect immediately, with no buffering.
- **Period changes:** take effect at the next boundary.

## Structure

- Package `pwm_pkg`:
  - default parameter constants (`PWM_NUM_CH`, `PWM_CNT_W`, `PWM_PRESC_W`);
  - the reset constant for `period_act`.
- Sub-module `pwm_channel`, instantiated NUM_CH times via generate. It contains:
  - the shadow and active duty registers;
  - write decode match and forwarding;
  - the compare and the output register.
- The top level holds:
  - the prescaler;
  - the counter;
  - `period_act`;
  - boundary and `period_start` generation.

## Test plan

Defaults for all scenarios: NUM_CH=16, CNT_W=8, PRESC_W=8.

1. **Reset, then 50% duty.** Stimulus: reset; period=255, prescale=0, en_out=en_pwm=FFFF; write ch0=128. Required response: out=0 throughout and after reset. From 1 clock after the first boundary, out[0] repeats 128 high / 128 low, and period_start pulses every 256 clocks.
2. **Double buffer.** Stimulus: ch3 active at 192; write 64 at cnt=50. Required response: the current period stays 192 high; the next period is 64 high. A write landing exactly at cnt=period takes effect immediately.
3. **Enable modes.** Stimulus: en_out[5]=1, en_pwm[5]=0. Required response: out[5]=1 constantly. With en_out[5]=0, out[5]=0 regardless of en_pwm or duty. Writes with duty_wr_ch out of range are ignored when NUM_CH=12.
4. **Extremes.**
   - Duty 0: output always 0.
   - Duty 256 with period=255: output always 1.
   - period=0, prescale=0, duty 1: output constant 1, period_start high every cycle.
5. **Prescaler.** Stimulus: prescale=3, period=9, duty 5. Required response: period = 40 clocks, 20 high. Dropping prescale from 200 to 3 while presc_cnt=100 ticks on the next clock.
6. **Reset mid-period.** Stimulus: assert rst while out[0]=1. Required response: the next cycle has out=0, cnt=0 and all duties 0. No output goes high until a new duty write passes a boundary.
